// File: rtl/nn_pkg.sv
// Shared definitions for the classifier front end:
// loader state encoding and datapath widths.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_START,
        S_WAIT_NN
    } ld_state_e;

    localparam int NUM_PIXELS_DEF = 784;
    localparam int DATA_W         = 32;
    localparam int ADDR_W         = 16;

endpackage

// File: rtl/image_loader.sv
// Streams pixel bytes into image memory as fixed-point words, then
// kicks the classifier and latches its result.
module image_loader
    import nn_pkg::*;
#(
    parameter int NUM_PIXELS = NUM_PIXELS_DEF,
    parameter int FRAC_SHIFT = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              pix_valid,
    input  logic [7:0]        pix_data,
    output logic              pix_ready,
    input  logic              abort,
    output logic [ADDR_W-1:0] img_write_addr,
    output logic [DATA_W-1:0] img_write_data,
    output logic              img_write_enable,
    output logic              nn_start,
    input  logic              nn_done,
    input  logic [3:0]        nn_argmax,
    output logic [3:0]        result,
    output logic              result_valid,
    output logic              busy,
    output logic [7:0]        frame_count
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic [3:0]        res_q, res_d;
    logic              rv_q, rv_d;
    logic [7:0]        fc_q, fc_d;

    logic              xfer;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] pix_word;

    assign pix_ready = ((state_q == S_IDLE) || (state_q == S_LOAD)) && !abort;
    assign xfer      = pix_valid && pix_ready;
    // A transfer in IDLE always opens a new frame at index 0.
    assign idx       = (state_q == S_IDLE) ? '0 : cnt_q;
    assign pix_word  = {{(DATA_W-8){1'b0}}, pix_data} << FRAC_SHIFT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        res_d   = res_q;
        rv_d    = rv_q;
        fc_d    = fc_q;

        if (xfer) begin
            wen_d   = 1'b1;
            waddr_d = idx;
            wdata_d = pix_word;
            cnt_d   = idx + 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    rv_d    = 1'b0;
                    state_d = (idx == LAST_IDX) ? S_FLUSH : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort)
                    state_d = S_IDLE;
                else if (xfer && idx == LAST_IDX)
                    state_d = S_FLUSH;
            end
            S_FLUSH: begin
                state_d = abort ? S_IDLE : S_START;
            end
            S_START: begin
                state_d = S_WAIT_NN;
            end
            S_WAIT_NN: begin
                if (nn_done) begin
                    res_d   = nn_argmax;
                    rv_d    = 1'b1;
                    fc_d    = fc_q + 8'd1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            fc_q    <= fc_d;
        end
    end

    assign img_write_addr   = waddr_q;
    assign img_write_data   = wdata_q;
    assign img_write_enable = wen_q;
    assign nn_start         = (state_q == S_START);
    assign busy             = (state_q != S_IDLE);
    assign result           = res_q;
    assign result_valid     = rv_q;
    assign frame_count      = fc_q;

endmodule

// File: tb/tb_image_loader.sv
// Randomized bench for image_loader against a frame-level model,
// plus a short-frame instance for the frame counter wrap.
module tb_image_loader;
    import nn_pkg::*;

    localparam int NP = 784;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = '0;
    logic        abort = 1'b0;
    logic        nn_done = 1'b0;
    logic [3:0]  nn_argmax = '0;

    logic        pix_ready;
    logic [15:0] img_write_addr;
    logic [31:0] img_write_data;
    logic        img_write_enable;
    logic        nn_start;
    logic [3:0]  result;
    logic        result_valid;
    logic        busy;
    logic [7:0]  frame_count;

    image_loader #(.NUM_PIXELS(NP), .FRAC_SHIFT(8)) dut (
        .clk(clk), .resetn(resetn),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .abort(abort),
        .img_write_addr(img_write_addr), .img_write_data(img_write_data),
        .img_write_enable(img_write_enable),
        .nn_start(nn_start), .nn_done(nn_done), .nn_argmax(nn_argmax),
        .result(result), .result_valid(result_valid),
        .busy(busy), .frame_count(frame_count)
    );

    // Short-frame instance used only to reach the counter wrap quickly.
    logic        s_valid = 1'b0;
    logic        s_done = 1'b0;
    logic        s_ready, s_wen, s_start, s_rv, s_busy;
    logic [15:0] s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_result;
    logic [7:0]  s_fc;

    image_loader #(.NUM_PIXELS(4), .FRAC_SHIFT(8)) dut_small (
        .clk(clk), .resetn(resetn),
        .pix_valid(s_valid), .pix_data(8'h3C), .pix_ready(s_ready),
        .abort(1'b0),
        .img_write_addr(s_addr), .img_write_data(s_data),
        .img_write_enable(s_wen),
        .nn_start(s_start), .nn_done(s_done), .nn_argmax(4'd9),
        .result(s_result), .result_valid(s_rv),
        .busy(s_busy), .frame_count(s_fc)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- frame-level reference model ----------------
    // m_n: pixels accepted in the open frame; m_tail: cycles since the
    // frame's last pixel (1 = last write, 2 = start pulse); m_wait: run busy.
    int          m_n, m_tail, m_fc, m_addr;
    bit          m_wait, m_wen, m_rv;
    logic [31:0] m_data;
    logic [3:0]  m_res;

    always @(posedge clk or negedge resetn) begin
        bit rdy, x;
        if (!resetn) begin
            m_n = 0; m_tail = 0; m_wait = 0; m_wen = 0;
            m_addr = 0; m_data = 0; m_res = 0; m_rv = 0; m_fc = 0;
        end else begin
            rdy   = (m_tail == 0) && !m_wait && !abort;
            x     = pix_valid && rdy;
            m_wen = x;
            if (x) begin
                m_addr = m_n;
                m_data = 32'(pix_data) * 256;
            end
            if (m_tail == 1) begin
                if (abort) begin m_tail = 0; m_n = 0; end
                else m_tail = 2;
            end else if (m_tail == 2) begin
                m_tail = 0; m_wait = 1; m_n = 0;
            end else if (m_wait) begin
                if (nn_done) begin
                    m_res = nn_argmax; m_rv = 1;
                    m_fc = (m_fc + 1) % 256; m_wait = 0;
                end
            end else if (abort) begin
                m_n = 0;
            end else if (x) begin
                if (m_n == 0) m_rv = 0;
                m_n++;
                if (m_n == NP) m_tail = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_outs", {img_write_addr, img_write_data, img_write_enable,
                             nn_start, result, result_valid, frame_count, busy}, '0);
        end else begin
            chk("busy",  busy, (m_n > 0) || (m_tail > 0) || m_wait);
            chk("ready", pix_ready, (m_tail == 0) && !m_wait && !abort);
            chk("wen",   img_write_enable, m_wen);
            if (m_wen) begin
                chk("waddr", img_write_addr, m_addr);
                chk("wdata", img_write_data, m_data);
            end
            chk("start", nn_start, m_tail == 2);
            chk("excl",  img_write_enable && nn_start, 0);
            chk("result", result, m_res);
            chk("rvalid", result_valid, m_rv);
            chk("fcount", frame_count, m_fc);
        end
    end

    // ---------------- write / start monitor ----------------
    int          xq[$];
    int          nwrites = 0, nstarts = 0, start_cyc = 0, last_xfer = 0;
    int          last_waddr = 0;
    logic [31:0] mem [0:NP-1];

    always @(negedge clk) begin
        if (resetn) begin
            if (img_write_enable) begin
                nwrites++;
                chk("wr_has_xfer", xq.size() > 0, 1);
                if (xq.size() > 0) chk("wr_lat", cyc - xq.pop_front(), 1);
                if (img_write_addr != 0) chk("contig", img_write_addr, last_waddr + 1);
                last_waddr = int'(img_write_addr);
                if (img_write_addr < NP) mem[img_write_addr] = img_write_data;
            end
            if (nn_start) begin
                nstarts++;
                start_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv(input bit v, input logic [7:0] d, input bit ab,
                       input bit dn, input logic [3:0] am, output bit acc);
        @(negedge clk); #1;
        pix_valid = v; pix_data = d; abort = ab; nn_done = dn; nn_argmax = am;
        #2;
        acc = v && pix_ready && resetn;
        if (acc) begin
            xq.push_back(cyc);
            last_xfer = cyc;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) drv(0, 8'h00, 0, 0, 4'd0, a);
    endtask

    // Send pixels k0..k1-1; mode 0 uses index mod 256, else random bytes.
    task automatic send(input int k0, input int k1, input int stall_pct, input int mode);
        bit a;
        int k = k0;
        int budget = 0;
        while (k < k1 && budget < 20000) begin
            bit v = ($urandom_range(99) >= stall_pct);
            logic [7:0] d = (mode == 0) ? 8'(k % 256) : 8'($urandom);
            drv(v, d, 0, 0, 4'd0, a);
            if (a) k++;
            budget++;
        end
        chk("send_timeout", k, k1);
        idle(1);
    endtask

    task automatic wait_start();
        int s0 = nstarts;
        for (int i = 0; i < 20 && nstarts == s0; i++) idle(1);
        chk("start_seen", nstarts - s0, 1);
    endtask

    task automatic finish_nn(input logic [3:0] am);
        bit a;
        drv(0, 8'h00, 0, 1, am, a);
        idle(2);
    endtask

    task automatic pulse_reset();
        @(negedge clk); #3;
        resetn = 1'b0;
        xq.delete();
        #1;
        chk("rst_async", {img_write_addr, img_write_data, img_write_enable,
                          nn_start, result, result_valid, frame_count, busy}, '0);
        @(negedge clk); @(negedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic first_pixel(input logic [7:0] d);
        bit a = 0;
        int n = 0;
        while (!a && n < 100) begin
            drv($urandom_range(1), d, 0, 0, 4'd0, a);
            n++;
        end
        @(posedge clk); #1;
        chk("first_acc", a, 1);
        chk("first_addr0", img_write_addr, 0);
        chk("first_rv_clr", result_valid, 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int nw0, ns0, sdone;
        bit a;

        #1 resetn = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("reset_busy", busy, 0);
        chk("reset_fc", frame_count, 0);
        resetn = 1'b1;
        idle(2);

        // Full back-to-back frame.
        nw0 = nwrites; ns0 = nstarts;
        send(0, NP, 0, 0);
        idle(4);
        chk("mem5", mem[5], 32'h0000_0500);
        chk("mem783", mem[783], 32'h0000_0F00);
        chk("last_addr", last_waddr, 783);
        chk("n_writes", nwrites - nw0, NP);
        chk("one_start", nstarts - ns0, 1);
        chk("start_delay", start_cyc - last_xfer, 2);
        finish_nn(4'd7);
        chk("res7", result, 7);
        chk("rv1", result_valid, 1);
        chk("fc1", frame_count, 1);
        chk("idle", busy, 0);

        // Stray completion while idle is ignored.
        finish_nn(4'd3);
        chk("stray_res", result, 7);
        chk("stray_fc", frame_count, 1);

        // Randomly stalled stream with random data.
        nw0 = nwrites;
        first_pixel(8'($urandom));
        send(1, NP, 50, 1);
        chk("stall_writes", nwrites - nw0, NP);
        chk("stall_last", last_waddr, 783);
        wait_start();
        finish_nn(4'($urandom_range(15)));

        // Abort after 300 pixels, then a clean frame.
        ns0 = nstarts;
        send(0, 300, 20, 1);
        drv(1, 8'hAA, 1, 0, 4'd0, a);
        chk("abort_ready", pix_ready, 0);
        chk("abort_noacc", a, 0);
        drv(1, 8'hAB, 1, 0, 4'd0, a);
        idle(2);
        chk("abort_idle", busy, 0);
        first_pixel(8'h11);
        send(1, NP - 1, 10, 1);
        idle(4);
        chk("no_early_start", nstarts - ns0, 0);
        send(NP - 1, NP, 0, 1);
        wait_start();
        finish_nn(4'd12);

        // Abort on the final write cycle suppresses the start.
        ns0 = nstarts;
        send(0, NP - 1, 0, 1);
        drv(1, 8'h55, 0, 0, 4'd0, a);
        drv(0, 8'h00, 1, 0, 4'd0, a);
        idle(6);
        chk("flush_abort", nstarts - ns0, 0);

        // Reset mid-frame, then reset while the classifier runs.
        send(0, 100, 30, 1);
        pulse_reset();
        idle(1);
        first_pixel(8'h80);
        send(1, NP, 0, 1);
        wait_start();
        idle(3);
        chk("wait_busy", busy, 1);
        pulse_reset();
        idle(1);
        finish_nn(4'd5);
        chk("post_rst_res", result, 0);
        chk("post_rst_fc", frame_count, 0);

        // Frame counter wrap on the short-frame instance.
        sdone = 0;
        @(negedge clk); #1;
        s_valid = 1'b1;
        s_done  = 1'b1;
        for (int i = 0; i < 5000 && sdone < 256; i++) begin
            @(negedge clk);
            if (s_start) begin
                chk("wrap_fc", s_fc, sdone % 256);
                sdone++;
            end
        end
        chk("wrap_frames", sdone, 256);
        #1 s_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrap_zero", s_fc, 0);
        chk("wrap_rv", s_rv, 1);
        chk("wrap_res", s_result, 9);
        s_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
